// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - Galaga default timing constants and the sync/blank flag bundle
// Contents:
//   GALAGA_*  : default raster timing (pixels/lines) used as parameter defaults by video_timing_gen
//   vt_flags_t: per-pixel sync/blank flags carried through the pixel-latency pipeline
package video_timing_pkg;

    localparam int GALAGA_H_TOTAL  = 384;
    localparam int GALAGA_H_ACTIVE = 288;
    localparam int GALAGA_HS_START = 320;
    localparam int GALAGA_HS_WIDTH = 32;
    localparam int GALAGA_V_TOTAL  = 264;
    localparam int GALAGA_V_ACTIVE = 224;
    localparam int GALAGA_VS_START = 240;
    localparam int GALAGA_VS_WIDTH = 4;
    localparam int GALAGA_CE_DIV   = 4;
    localparam int GALAGA_PIX_LAT  = 2;

    // Counters are 9 bits wide, so totals above 512 cannot be represented.
    localparam int CNT_W   = 9;
    localparam int CNT_MAX = 512;

    typedef struct packed {
        logic hblank;
        logic vblank;
        logic hs;
        logic vs;
    } vt_flags_t;

    localparam int FLAGS_W = $bits(vt_flags_t);

endpackage

// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - Pixel-side bundle between the timing generator and the video core/display
// Signals:
//   pix_ce, hcnt, vcnt        : pixel clock enable and fetch coordinates (generator -> core)
//   r_in, g_in, b_in          : core pixel data for {hcnt,vcnt}, PIX_LAT ticks late (core -> generator)
//   R, G, B                   : aligned, blanked pixel data (generator -> display)
//   HSync, VSync              : positive sync pulses aligned with R/G/B
//   HBlank, VBlank            : blanking flags aligned with R/G/B
//   h_offset                  : signed HSync offset, only with VIDEO_TIMING_HOFFSET_EN defined
// Modports: master = timing generator, slave = core/display side.
interface video_timing_gen_if;

    logic       pix_ce;
    logic [8:0] hcnt;
    logic [8:0] vcnt;
    logic [7:0] r_in;
    logic [7:0] g_in;
    logic [7:0] b_in;
    logic [7:0] R;
    logic [7:0] G;
    logic [7:0] B;
    logic       HSync;
    logic       VSync;
    logic       HBlank;
    logic       VBlank;
`ifdef VIDEO_TIMING_HOFFSET_EN
    logic [3:0] h_offset;

    modport master (
        output pix_ce, hcnt, vcnt, R, G, B, HSync, VSync, HBlank, VBlank,
        input  r_in, g_in, b_in, h_offset
    );

    modport slave (
        input  pix_ce, hcnt, vcnt, R, G, B, HSync, VSync, HBlank, VBlank,
        output r_in, g_in, b_in, h_offset
    );
`else
    modport master (
        output pix_ce, hcnt, vcnt, R, G, B, HSync, VSync, HBlank, VBlank,
        input  r_in, g_in, b_in
    );

    modport slave (
        input  pix_ce, hcnt, vcnt, R, G, B, HSync, VSync, HBlank, VBlank,
        output r_in, g_in, b_in
    );
`endif

endinterface

// File: rtl/video_delay_line.sv
// rtl/video_delay_line.sv - Enable-gated shift register of configurable depth
// Ports:
//   clk_sys, reset_n : clock, asynchronous active-low reset (clears every stage)
//   en               : shift enable (pix_ce)
//   din              : value entering stage 0
//   tap              : value about to enter the last stage (din itself when DEPTH==1)
//   dout             : last stage
module video_delay_line #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 1
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] tap,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH < 1) begin : g_bad_depth
            $error("video_delay_line: DEPTH must be at least 1");
        end
        if (WIDTH < 1) begin : g_bad_width
            $error("video_delay_line: WIDTH must be at least 1");
        end
    endgenerate

    logic [DEPTH-1:0][WIDTH-1:0] stage;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            stage <= '0;
        end else if (en) begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    // The tap lets a register placed beside the last stage see the same
    // flags the last stage is about to load.
    generate
        if (DEPTH == 1) begin : g_tap_din
            assign tap = din;
        end else begin : g_tap_stage
            assign tap = stage[DEPTH-2];
        end
    endgenerate

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - Raster timing generator with pixel-latency-aligned RGB, sync and blank outputs
// Ports:
//   clk_sys : sole clock
//   reset_n : asynchronous active-low reset
//   vif     : video_timing_gen_if.master (pix_ce, hcnt, vcnt, r_in/g_in/b_in, R/G/B,
//             HSync/VSync, HBlank/VBlank, and h_offset when enabled)
// Optional feature macro: VIDEO_TIMING_HOFFSET_EN adds a signed 4-bit HSync offset,
// latched once per frame at hcnt==0, vcnt==0; without it the offset is fixed at 0.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_TOTAL  = GALAGA_H_TOTAL,
    parameter int H_ACTIVE = GALAGA_H_ACTIVE,
    parameter int HS_START = GALAGA_HS_START,
    parameter int HS_WIDTH = GALAGA_HS_WIDTH,
    parameter int V_TOTAL  = GALAGA_V_TOTAL,
    parameter int V_ACTIVE = GALAGA_V_ACTIVE,
    parameter int VS_START = GALAGA_VS_START,
    parameter int VS_WIDTH = GALAGA_VS_WIDTH,
    parameter int CE_DIV   = GALAGA_CE_DIV,
    parameter int PIX_LAT  = GALAGA_PIX_LAT
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    video_timing_gen_if.master vif
);

    generate
        if (CE_DIV < 2 || CE_DIV > 16) begin : g_bad_ce_div
            $error("video_timing_gen: CE_DIV must be in 2..16");
        end
        if (PIX_LAT < 0 || PIX_LAT > 7) begin : g_bad_pix_lat
            $error("video_timing_gen: PIX_LAT must be in 0..7");
        end
        if (H_TOTAL < 2 || H_TOTAL > CNT_MAX || V_TOTAL < 2 || V_TOTAL > CNT_MAX) begin : g_bad_total
            $error("video_timing_gen: H_TOTAL/V_TOTAL must be in 2..512");
        end
        if (H_ACTIVE < 1 || H_ACTIVE > H_TOTAL || V_ACTIVE < 1 || V_ACTIVE > V_TOTAL) begin : g_bad_active
            $error("video_timing_gen: active area exceeds the total raster");
        end
        if (HS_WIDTH < 1 || HS_START < 0 || HS_START + HS_WIDTH > H_TOTAL) begin : g_bad_hsync
            $error("video_timing_gen: HSync window falls outside the line");
        end
        if (VS_WIDTH < 1 || VS_START < 0 || VS_START + VS_WIDTH > V_TOTAL) begin : g_bad_vsync
            $error("video_timing_gen: VSync window falls outside the frame");
        end
`ifdef VIDEO_TIMING_HOFFSET_EN
        if (HS_START < 8 || HS_START + HS_WIDTH + 7 > H_TOTAL) begin : g_bad_hoffset
            $error("video_timing_gen: HSync window plus offset range -8..7 falls outside the line");
        end
`endif
    endgenerate

    // ------------------------------------------------------------------
    // Pixel clock enable: combinational decode of the divider so that it
    // drops to 0 the instant reset_n is asserted.
    // ------------------------------------------------------------------
    logic [3:0] div;
    logic       pix_ce;

    assign pix_ce = (div == 4'(CE_DIV - 1));

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            div <= '0;
        end else if (pix_ce) begin
            div <= '0;
        end else begin
            div <= div + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Fetch coordinates
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    logic             h_last;
    logic             v_last;

    assign h_last = (int'(hcnt) == H_TOTAL - 1);
    assign v_last = (int'(vcnt) == V_TOTAL - 1);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pix_ce) begin
            if (h_last) begin
                hcnt <= '0;
                vcnt <= v_last ? '0 : vcnt + 9'd1;
            end else begin
                hcnt <= hcnt + 9'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // HSync offset. Latching only at frame start keeps a mid-frame change
    // from tearing the current frame's sync.
    // ------------------------------------------------------------------
    logic signed [3:0] hoff;

`ifdef VIDEO_TIMING_HOFFSET_EN
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hoff <= '0;
        end else if (pix_ce && hcnt == '0 && vcnt == '0) begin
            hoff <= vif.h_offset;
        end
    end
`else
    assign hoff = 4'sd0;
`endif

    // Window bounds are signed so a negative offset compares correctly.
    logic signed [10:0] hpos;
    logic signed [10:0] hs_lo;
    logic signed [10:0] hs_hi;

    assign hpos  = {2'b00, hcnt};
    assign hs_lo = 11'(HS_START) + {{7{hoff[3]}}, hoff};
    assign hs_hi = hs_lo + 11'(HS_WIDTH);

    // ------------------------------------------------------------------
    // Raw flags for the coordinate currently being fetched
    // ------------------------------------------------------------------
    vt_flags_t raw;

    always_comb begin
        raw        = '0;
        raw.hblank = (int'(hcnt) >= H_ACTIVE);
        raw.vblank = (int'(vcnt) >= V_ACTIVE);
        raw.hs     = (hpos >= hs_lo) && (hpos < hs_hi);
        raw.vs     = (int'(vcnt) >= VS_START) && (int'(vcnt) < VS_START + VS_WIDTH);
    end

    // ------------------------------------------------------------------
    // Flag pipeline: PIX_LAT+1 stages so the flags leave together with the
    // pixel data that the core returns PIX_LAT ticks late and that the
    // colour register below adds one more tick to.
    // ------------------------------------------------------------------
    logic [FLAGS_W-1:0] tap_bits;
    logic [FLAGS_W-1:0] out_bits;
    vt_flags_t          tap;
    vt_flags_t          flags_out;

    video_delay_line #(
        .WIDTH (FLAGS_W),
        .DEPTH (PIX_LAT + 1)
    ) u_flag_dly (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .en      (pix_ce),
        .din     (raw),
        .tap     (tap_bits),
        .dout    (out_bits)
    );

    assign tap       = vt_flags_t'(tap_bits);
    assign flags_out = vt_flags_t'(out_bits);

    // ------------------------------------------------------------------
    // Colour register. It loads in step with the last flag stage, so it
    // blanks on the tap (the flags that stage is about to hold).
    // ------------------------------------------------------------------
    logic [7:0] r_q;
    logic [7:0] g_q;
    logic [7:0] b_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= '0;
            g_q <= '0;
            b_q <= '0;
        end else if (pix_ce) begin
            if (tap.hblank || tap.vblank) begin
                r_q <= '0;
                g_q <= '0;
                b_q <= '0;
            end else begin
                r_q <= vif.r_in;
                g_q <= vif.g_in;
                b_q <= vif.b_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign vif.pix_ce = pix_ce;
    assign vif.hcnt   = hcnt;
    assign vif.vcnt   = vcnt;
    assign vif.R      = r_q;
    assign vif.G      = g_q;
    assign vif.B      = b_q;
    assign vif.HSync  = flags_out.hs;
    assign vif.VSync  = flags_out.vs;
    assign vif.HBlank = flags_out.hblank;
    assign vif.VBlank = flags_out.vblank;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - Directed self-checking bench for video_timing_gen (default and small raster instances)
module tb_video_timing_gen;

    // Instance A: default Galaga timing
    localparam int A_HT = 384, A_HA = 288, A_HSS = 320, A_HSW = 32;
    localparam int A_VT = 264, A_VA = 224, A_VSS = 240, A_VSW = 4;
    localparam int A_CE = 4, A_LAT = 2;
    // Instance S: small raster, fastest divider, zero fetch latency
    localparam int S_HT = 32, S_HA = 16, S_HSS = 20, S_HSW = 3;
    localparam int S_VT = 64, S_VA = 48, S_VSS = 52, S_VSW = 3;
    localparam int S_CE = 2, S_LAT = 0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs;
        logic       vs;
        logic       hb;
        logic       vb;
    } vid_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   e        = 0;   // rising clk_sys edges since reset release

    video_timing_gen_if ifa ();
    video_timing_gen_if ifs ();

    video_timing_gen #(
        .H_TOTAL (A_HT), .H_ACTIVE (A_HA), .HS_START (A_HSS), .HS_WIDTH (A_HSW),
        .V_TOTAL (A_VT), .V_ACTIVE (A_VA), .VS_START (A_VSS), .VS_WIDTH (A_VSW),
        .CE_DIV (A_CE), .PIX_LAT (A_LAT)
    ) dut_a (
        .clk_sys (clk),
        .reset_n (reset_n),
        .vif     (ifa)
    );

    video_timing_gen #(
        .H_TOTAL (S_HT), .H_ACTIVE (S_HA), .HS_START (S_HSS), .HS_WIDTH (S_HSW),
        .V_TOTAL (S_VT), .V_ACTIVE (S_VA), .VS_START (S_VSS), .VS_WIDTH (S_VSW),
        .CE_DIV (S_CE), .PIX_LAT (S_LAT)
    ) dut_s (
        .clk_sys (clk),
        .reset_n (reset_n),
        .vif     (ifs)
    );

    always #5 clk = ~clk;

`ifdef VIDEO_TIMING_HOFFSET_EN
    initial begin
        ifa.h_offset = 4'd0;
        ifs.h_offset = 4'd0;
    end
`endif

    vid_t obs_a;
    vid_t obs_s;
    assign obs_a = {ifa.R, ifa.G, ifa.B, ifa.HSync, ifa.VSync, ifa.HBlank, ifa.VBlank};
    assign obs_s = {ifs.R, ifs.G, ifs.B, ifs.HSync, ifs.VSync, ifs.HBlank, ifs.VBlank};

    // Pixel content the bench's core returns for raster index idx (pixels since frame 0 start).
    function automatic logic [23:0] m_data(int idx, int ht, int vt);
        int h;
        int v;
        if (idx < 0) return 24'd0;
        h = idx % ht;
        v = (idx / ht) % vt;
        return {8'(h), 8'(v), 8'(h + v) ^ 8'h5A};
    endfunction

    function automatic vid_t m_out(int idx, int ht, int ha, int hss, int hsw,
                                   int vt, int va, int vss, int vsw);
        vid_t o;
        int   h;
        int   v;
        o = '0;
        if (idx < 0) return o;
        h = idx % ht;
        v = (idx / ht) % vt;
        o.hb = (h >= ha);
        o.vb = (v >= va);
        o.hs = (h >= hss) && (h < hss + hsw);
        o.vs = (v >= vss) && (v < vss + vsw);
        if (!o.hb && !o.vb) {o.r, o.g, o.b} = m_data(idx, ht, vt);
        return o;
    endfunction

    // After ee edges, ee/CE ticks have happened; outputs show index ticks-PIX_LAT-1.
    function automatic vid_t exp_a(int ee);
        return m_out(ee / A_CE - A_LAT - 1, A_HT, A_HA, A_HSS, A_HSW, A_VT, A_VA, A_VSS, A_VSW);
    endfunction

    function automatic vid_t exp_s(int ee);
        return m_out(ee / S_CE - S_LAT - 1, S_HT, S_HA, S_HSS, S_HSW, S_VT, S_VA, S_VSS, S_VSW);
    endfunction

    // The next tick fetches index ee/CE; the core answers for index ee/CE-PIX_LAT.
    task automatic drive_inputs();
        {ifa.r_in, ifa.g_in, ifa.b_in} = m_data(e / A_CE - A_LAT, A_HT, A_VT);
        {ifs.r_in, ifs.g_in, ifs.b_in} = m_data(e / S_CE - S_LAT, S_HT, S_VT);
    endtask

    task automatic step();
        @(posedge clk);
        e++;
        @(negedge clk);
        drive_inputs();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        e = 0;
        drive_inputs();
        repeat (3) @(negedge clk);
        checks++; if (ifa.pix_ce !== 1'b0) begin failures++; $display("FAIL reset_pix_ce_a got=%b exp=0", ifa.pix_ce); end
        checks++; if (ifa.hcnt !== 9'd0) begin failures++; $display("FAIL reset_hcnt_a got=%0d exp=0", ifa.hcnt); end
        checks++; if (ifa.vcnt !== 9'd0) begin failures++; $display("FAIL reset_vcnt_a got=%0d exp=0", ifa.vcnt); end
        checks++; if (obs_a !== '0) begin failures++; $display("FAIL reset_out_a got=%h exp=0", obs_a); end
        checks++; if (ifs.pix_ce !== 1'b0) begin failures++; $display("FAIL reset_pix_ce_s got=%b exp=0", ifs.pix_ce); end
        checks++; if (ifs.hcnt !== 9'd0) begin failures++; $display("FAIL reset_hcnt_s got=%0d exp=0", ifs.hcnt); end
        checks++; if (ifs.vcnt !== 9'd0) begin failures++; $display("FAIL reset_vcnt_s got=%0d exp=0", ifs.vcnt); end
        checks++; if (obs_s !== '0) begin failures++; $display("FAIL reset_out_s got=%h exp=0", obs_s); end
        reset_n = 1'b1;
        e = 0;
        drive_inputs();
    endtask

    task automatic test_pix_ce();
        repeat (16) begin
            step();
            checks++;
            if (ifa.pix_ce !== ((e % A_CE) == A_CE - 1)) begin
                failures++; $display("FAIL pix_ce_a e=%0d got=%b exp=%b", e, ifa.pix_ce, (e % A_CE) == A_CE - 1);
            end
            checks++;
            if (ifs.pix_ce !== ((e % S_CE) == S_CE - 1)) begin
                failures++; $display("FAIL pix_ce_s e=%0d got=%b exp=%b", e, ifs.pix_ce, (e % S_CE) == S_CE - 1);
            end
            checks++;
            if (ifa.hcnt !== 9'(e / A_CE)) begin
                failures++; $display("FAIL first_ticks_hcnt_a e=%0d got=%0d exp=%0d", e, ifa.hcnt, e / A_CE);
            end
        end
    endtask

    task automatic test_line_wrap();
        logic [8:0] prev_h;
        bit         saw_wrap;
        vid_t       ex;
        prev_h   = ifa.hcnt;
        saw_wrap = 1'b0;
        while (e < (A_HT + 4) * A_CE) begin
            step();
            checks++;
            if (ifa.hcnt !== 9'((e / A_CE) % A_HT) || ifa.vcnt !== 9'((e / A_CE) / A_HT)) begin
                failures++;
                $display("FAIL line_counters_a e=%0d got=%0d,%0d exp=%0d,%0d", e, ifa.hcnt, ifa.vcnt,
                         (e / A_CE) % A_HT, (e / A_CE) / A_HT);
            end
            ex = exp_a(e);
            checks++;
            if (obs_a !== ex) begin
                failures++; $display("FAIL line_out_a e=%0d got=%h exp=%h", e, obs_a, ex);
            end
            if (prev_h == 9'd383 && ifa.hcnt == 9'd0 && ifa.vcnt == 9'd1) saw_wrap = 1'b1;
            prev_h = ifa.hcnt;
        end
        checks++;
        if (!saw_wrap) begin failures++; $display("FAIL hcnt_wrap_383_to_0 got=0 exp=1"); end
    endtask

    task automatic test_alignment();
        int   hs_ticks;
        int   rises;
        logic prev_hs;
        vid_t ex;
        hs_ticks = 0;
        rises    = 0;
        prev_hs  = ifa.HSync;
        repeat (A_HT * A_CE) begin
            step();
            ex = exp_a(e);
            checks++;
            if (obs_a !== ex) begin
                failures++; $display("FAIL align_out_a e=%0d got=%h exp=%h", e, obs_a, ex);
            end
            checks++;
            if (ifa.HBlank === 1'b1 && ifa.R !== 8'd0) begin
                failures++; $display("FAIL r_blank_a e=%0d got=%0d exp=0", e, ifa.R);
            end
            if ((e % A_CE) == 0 && ifa.HSync === 1'b1) hs_ticks++;
            if (ifa.HSync === 1'b1 && prev_hs === 1'b0) begin
                rises++;
                checks++;
                if ((e / A_CE) % A_HT != A_HSS + A_LAT + 1) begin
                    failures++; $display("FAIL hsync_rise_tick got=%0d exp=%0d", (e / A_CE) % A_HT, A_HSS + A_LAT + 1);
                end
            end
            prev_hs = ifa.HSync;
        end
        checks++;
        if (hs_ticks != A_HSW) begin failures++; $display("FAIL hsync_width_a got=%0d exp=%0d", hs_ticks, A_HSW); end
        checks++;
        if (rises != 1) begin failures++; $display("FAIL hsync_rises_a got=%0d exp=1", rises); end
    endtask

    task automatic test_small_frame();
        int         vs_ticks;
        int         wraps;
        logic [8:0] prev_v;
        vid_t       ex;
        vs_ticks = 0;
        wraps    = 0;
        prev_v   = ifs.vcnt;
        repeat (S_HT * S_VT * S_CE) begin
            step();
            checks++;
            if (ifs.hcnt !== 9'((e / S_CE) % S_HT) || ifs.vcnt !== 9'(((e / S_CE) / S_HT) % S_VT)) begin
                failures++;
                $display("FAIL frame_counters_s e=%0d got=%0d,%0d exp=%0d,%0d", e, ifs.hcnt, ifs.vcnt,
                         (e / S_CE) % S_HT, ((e / S_CE) / S_HT) % S_VT);
            end
            ex = exp_s(e);
            checks++;
            if (obs_s !== ex) begin
                failures++; $display("FAIL frame_out_s e=%0d got=%h exp=%h", e, obs_s, ex);
            end
            if ((e % S_CE) == 0 && ifs.VSync === 1'b1) vs_ticks++;
            if (prev_v == 9'(S_VT - 1) && ifs.vcnt == 9'd0) wraps++;
            prev_v = ifs.vcnt;
        end
        checks++;
        if (vs_ticks != S_VSW * S_HT) begin failures++; $display("FAIL vsync_width_s got=%0d exp=%0d", vs_ticks, S_VSW * S_HT); end
        checks++;
        if (wraps != 1) begin failures++; $display("FAIL vcnt_wrap_s got=%0d exp=1", wraps); end
    endtask

    task automatic test_reset_mid_frame();
        bit   found;
        vid_t ex;
        found = 1'b0;
        for (int i = 0; i < S_HT * S_VT * S_CE + 8 && !found; i++) begin
            step();
            if (ifs.hcnt == 9'd10 && ifs.vcnt == 9'd50) found = 1'b1;
        end
        checks++;
        if (!found) begin failures++; $display("FAIL reach_10_50 got=0 exp=1"); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (ifa.pix_ce !== 1'b0 || ifs.pix_ce !== 1'b0) begin failures++; $display("FAIL async_pix_ce got=%b%b exp=00", ifa.pix_ce, ifs.pix_ce); end
        checks++; if (ifa.hcnt !== 9'd0 || ifa.vcnt !== 9'd0) begin failures++; $display("FAIL async_cnt_a got=%0d,%0d exp=0,0", ifa.hcnt, ifa.vcnt); end
        checks++; if (ifs.hcnt !== 9'd0 || ifs.vcnt !== 9'd0) begin failures++; $display("FAIL async_cnt_s got=%0d,%0d exp=0,0", ifs.hcnt, ifs.vcnt); end
        checks++; if (obs_a !== '0) begin failures++; $display("FAIL async_out_a got=%h exp=0", obs_a); end
        checks++; if (obs_s !== '0) begin failures++; $display("FAIL async_out_s got=%h exp=0", obs_s); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        e = 0;
        drive_inputs();
        repeat (3 * S_HT * S_CE) begin
            step();
            checks++;
            if (ifs.hcnt !== 9'((e / S_CE) % S_HT) || ifs.vcnt !== 9'((e / S_CE) / S_HT)) begin
                failures++;
                $display("FAIL restart_counters_s e=%0d got=%0d,%0d exp=%0d,%0d", e, ifs.hcnt, ifs.vcnt,
                         (e / S_CE) % S_HT, (e / S_CE) / S_HT);
            end
            ex = exp_s(e);
            checks++;
            if (obs_s !== ex) begin failures++; $display("FAIL restart_out_s e=%0d got=%h exp=%h", e, obs_s, ex); end
            ex = exp_a(e);
            checks++;
            if (obs_a !== ex || ifa.hcnt !== 9'(e / A_CE)) begin
                failures++; $display("FAIL restart_a e=%0d got=%h,%0d exp=%h,%0d", e, obs_a, ifa.hcnt, ex, e / A_CE);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pix_ce();
        test_line_wrap();
        test_alignment();
        test_small_frame();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
